// File: rtl/johnson_phase_decoder.sv
// Decodes a Johnson counter word into phase index/one-hot, checks sequence legality,
// tracks lock, counts lock losses and requests a counter resync when the ring is corrupt.
module johnson_phase_decoder #(
    parameter int WIDTH          = 4,
    parameter bit SHIFT_LEFT     = 1'b1,
    parameter int LOCK_CNT       = 4,
    parameter int RESYNC_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              count_in,
    output logic [2*WIDTH-1:0]            phase_onehot,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          phase_valid,
    output logic                          locked,
    output logic                          resync_req,
    output logic [7:0]                    err_count
);
    // state    | meaning
    // ACQUIRE  | legal words seen, counting consecutive good transitions
    // LOCKED   | LOCK_CNT good transitions in a row; any bad sample is a lock loss
    // RESYNC   | ring corrupt; counter reset requested, waiting for an all-zero word

    localparam int IDX_W = $clog2(2*WIDTH);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int TMR_W = (RESYNC_TIMEOUT > 1) ? $clog2(RESYNC_TIMEOUT) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        RESYNC  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [RUN_W-1:0]  good_run, good_run_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [7:0]        err_nxt;
    logic              resync_raw;
    logic              have_prev;
    logic [WIDTH-1:0]  prev_code;
    logic [WIDTH-1:0]  succ_prev;
    logic [WIDTH-1:0]  norm_word;
    logic              legal;
    logic              seq_ok;
    logic [IDX_W-1:0]  idx_dec;

    // Right-shifting counters are handled as the bit-reversed left-shifting case.
    function automatic logic [WIDTH-1:0] normalize(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = SHIFT_LEFT ? c[i] : c[WIDTH-1-i];
        end
        return r;
    endfunction

    // Legal iff the ones form a run anchored at bit0 or the zeros form a run anchored at bit0.
    function automatic logic is_legal(input logic [WIDTH-1:0] n);
        logic [WIDTH-1:0] inv;
        inv = ~n;
        return ((n & (n + ONE)) == '0) || ((inv & (inv + ONE)) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] decode_idx(input logic [WIDTH-1:0] n);
        int pc;
        pc = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pc += int'(n[i]);
        end
        if (!n[WIDTH-1]) return IDX_W'(pc);
        return IDX_W'(2*WIDTH - pc);
    endfunction

    assign succ_prev = SHIFT_LEFT ? {prev_code[WIDTH-2:0], ~prev_code[WIDTH-1]}
                                  : {~prev_code[0], prev_code[WIDTH-1:1]};
    assign norm_word = normalize(count_in);
    assign legal     = is_legal(norm_word);
    assign idx_dec   = decode_idx(norm_word);
    assign seq_ok    = have_prev && (count_in == succ_prev);
    assign locked    = (state == LOCKED);

    always_comb begin
        state_nxt    = state;
        good_run_nxt = good_run;
        timer_nxt    = timer;
        err_nxt      = err_count;
        resync_raw   = 1'b0;
        case (state)
            ACQUIRE: begin
                if (!legal) begin
                    state_nxt    = RESYNC;
                    resync_raw   = 1'b1;
                    good_run_nxt = '0;
                    timer_nxt    = '0;
                end else if (seq_ok) begin
                    if (good_run == RUN_W'(LOCK_CNT - 1)) begin
                        state_nxt    = LOCKED;
                        good_run_nxt = '0;
                    end else begin
                        good_run_nxt = good_run + RUN_W'(1);
                    end
                end else begin
                    good_run_nxt = '0;
                end
            end
            LOCKED: begin
                if (!(legal && seq_ok)) begin
                    if (err_count != 8'hFF) err_nxt = err_count + 8'd1;
                    good_run_nxt = '0;
                    if (!legal) begin
                        state_nxt  = RESYNC;
                        resync_raw = 1'b1;
                        timer_nxt  = '0;
                    end else begin
                        state_nxt = ACQUIRE;
                    end
                end
            end
            RESYNC: begin
                if (count_in == '0) begin
                    state_nxt    = ACQUIRE;
                    good_run_nxt = '0;
                    timer_nxt    = '0;
                end else if (timer == TMR_W'(RESYNC_TIMEOUT - 1)) begin
                    resync_raw = 1'b1;
                    timer_nxt  = '0;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: begin
                state_nxt    = ACQUIRE;
                good_run_nxt = '0;
                timer_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACQUIRE;
            good_run     <= '0;
            timer        <= '0;
            err_count    <= '0;
            resync_req   <= 1'b0;
            have_prev    <= 1'b0;
            prev_code    <= '0;
            phase_valid  <= 1'b0;
            phase_idx    <= '0;
            phase_onehot <= '0;
        end else begin
            state        <= state_nxt;
            good_run     <= good_run_nxt;
            timer        <= timer_nxt;
            err_count    <= err_nxt;
            // Back-to-back requests would hold the counter in reset; keep each one a single pulse.
            resync_req   <= resync_raw && !resync_req;
            have_prev    <= 1'b1;
            prev_code    <= count_in;
            phase_valid  <= legal;
            phase_idx    <= legal ? idx_dec : '0;
            phase_onehot <= legal ? ((2*WIDTH)'(1) << idx_dec) : '0;
        end
    end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: left-shift instance for decode/lock/resync/saturation,
// plus a right-shift instance for the reversed decode.
module tb_johnson_phase_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic [3:0] count_r;

    logic [7:0] phase_onehot, phase_onehot_r;
    logic [2:0] phase_idx, phase_idx_r;
    logic       phase_valid, phase_valid_r;
    logic       locked, locked_r;
    logic       resync_req, resync_req_r;
    logic [7:0] err_count, err_count_r;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    always #5 clk = ~clk;

    johnson_phase_decoder #(.WIDTH(4), .SHIFT_LEFT(1'b1), .LOCK_CNT(4), .RESYNC_TIMEOUT(16)) u_dut (
        .clk(clk), .reset(reset), .count_in(count_in),
        .phase_onehot(phase_onehot), .phase_idx(phase_idx), .phase_valid(phase_valid),
        .locked(locked), .resync_req(resync_req), .err_count(err_count)
    );

    johnson_phase_decoder #(.WIDTH(4), .SHIFT_LEFT(1'b0), .LOCK_CNT(4), .RESYNC_TIMEOUT(16)) u_dut_r (
        .clk(clk), .reset(reset), .count_in(count_r),
        .phase_onehot(phase_onehot_r), .phase_idx(phase_idx_r), .phase_valid(phase_valid_r),
        .locked(locked_r), .resync_req(resync_req_r), .err_count(err_count_r)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] c);
        count_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step_r(input logic [3:0] c);
        count_r = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pos;
        int exp_err;
        logic [3:0] seq1   [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        int         idx1   [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        int         lock1  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
        logic [3:0] seq_r  [6] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7};
        int         lock_r [6] = '{0, 0, 0, 0, 1, 1};

        reset    = 1'b1;
        count_in = 4'h0;
        count_r  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid",  phase_valid,  0);
        check_eq("rst_idx",    phase_idx,    0);
        check_eq("rst_onehot", phase_onehot, 0);
        check_eq("rst_locked", locked,       0);
        check_eq("rst_resync", resync_req,   0);
        check_eq("rst_err",    err_count,    0);
        reset = 1'b0;

        // full ring walk, lock at the 4th good transition
        for (int i = 0; i < 9; i++) begin
            step(seq1[i]);
            check_eq("walk_idx",    phase_idx,    idx1[i]);
            check_eq("walk_onehot", phase_onehot, 1 << idx1[i]);
            check_eq("walk_valid",  phase_valid,  1);
            check_eq("walk_locked", locked,       lock1[i]);
            check_eq("walk_resync", resync_req,   0);
        end

        // illegal word while locked
        step(4'h5);
        check_eq("ill_resync", resync_req,   1);
        check_eq("ill_locked", locked,       0);
        check_eq("ill_err",    err_count,    1);
        check_eq("ill_valid",  phase_valid,  0);
        check_eq("ill_idx",    phase_idx,    0);
        check_eq("ill_onehot", phase_onehot, 0);
        step(4'h0);
        check_eq("ill_resync_once", resync_req, 0);
        check_eq("ill_acq_locked",  locked,     0);
        for (int i = 1; i <= 4; i++) begin
            step(codes[i]);
            check_eq("ill_relock", locked, (i == 4) ? 1 : 0);
        end

        // legal but out-of-sequence words while locked
        step(4'h3);
        check_eq("skip_locked", locked,     0);
        check_eq("skip_err",    err_count,  2);
        check_eq("skip_resync", resync_req, 0);
        check_eq("skip_valid",  phase_valid, 1);
        step(4'hF);
        check_eq("skip2_err",    err_count,  2);
        check_eq("skip2_resync", resync_req, 0);
        check_eq("skip2_locked", locked,     0);
        for (int i = 5; i <= 8; i++) begin
            step(codes[i % 8]);
            check_eq("skip_relock", locked, (i == 8) ? 1 : 0);
        end
        check_eq("skip_relock_err", err_count, 2);

        // stuck in RESYNC: periodic resync requests
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step(4'h5);
            check_eq("tmo_pulse", resync_req, (cyc == 1 || cyc == 17 || cyc == 33) ? 1 : 0);
        end
        check_eq("tmo_err",    err_count, 3);
        check_eq("tmo_locked", locked,    0);
        step(4'h0);
        for (int i = 1; i <= 4; i++) begin
            step(codes[i]);
        end
        check_eq("tmo_relock", locked, 1);
        pos = 4;

        // err_count saturation
        exp_err = 3;
        for (int i = 0; i < 300; i++) begin
            pos = (pos + 2) % 8;
            step(codes[pos]);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            if (i % 50 == 49 || i == 299) check_eq("sat_err", err_count, exp_err);
            for (int k = 0; k < 4; k++) begin
                pos = (pos + 1) % 8;
                step(codes[pos]);
            end
        end
        check_eq("sat_err_final", err_count, 255);
        check_eq("sat_locked",    locked,    1);

        // lock loss and reset on the same edge: reset wins
        count_in = 4'h5;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst2_err",    err_count,   0);
        check_eq("rst2_locked", locked,      0);
        check_eq("rst2_resync", resync_req,  0);
        check_eq("rst2_valid",  phase_valid, 0);
        count_in = 4'h0;

        // right-shifting counter
        for (int i = 0; i < 6; i++) begin
            step_r(seq_r[i]);
            check_eq("rev_idx",    phase_idx_r,    i);
            check_eq("rev_onehot", phase_onehot_r, 1 << i);
            check_eq("rev_valid",  phase_valid_r,  1);
            check_eq("rev_locked", locked_r,       lock_r[i]);
        end
        step_r(4'hA);
        check_eq("rev_ill_resync", resync_req_r, 1);
        check_eq("rev_ill_err",    err_count_r,  1);
        check_eq("rev_ill_valid",  phase_valid_r, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
